// File: rtl/axi_sts_arb_pkg.sv
// Shared types and sizing helpers for the AXI4-Lite status read arbiter.
package axi_sts_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 32'd0;
    v      = (value > 32'd0) ? value - 32'd1 : 32'd0;
    while (v > 32'd0) begin
      result = result + 32'd1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // A grant index always needs at least one bit, even for a single master.
  function automatic int unsigned grant_width(input int unsigned n);
    return (clog2(n) < 32'd1) ? 32'd1 : clog2(n);
  endfunction

endpackage

// File: rtl/axi_sts_arb_if.sv
// Read-channel bundle between N requesting masters, the arbiter and the status slave.
interface axi_sts_arb_if #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16
);
  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_axi_araddr;
  logic [NUM_MASTERS-1:0]                s_axi_arvalid;
  logic [NUM_MASTERS-1:0]                s_axi_arready;
  logic [AXI_DATA_WIDTH-1:0]             s_axi_rdata;
  logic [1:0]                            s_axi_rresp;
  logic [NUM_MASTERS-1:0]                s_axi_rvalid;
  logic [NUM_MASTERS-1:0]                s_axi_rready;

  logic [AXI_ADDR_WIDTH-1:0]             m_axi_araddr;
  logic                                  m_axi_arvalid;
  logic                                  m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0]             m_axi_rdata;
  logic [1:0]                            m_axi_rresp;
  logic                                  m_axi_rvalid;
  logic                                  m_axi_rready;

  // The arbiter: slave towards the masters, master towards the status slave.
  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    output m_axi_araddr, m_axi_arvalid, m_axi_rready
  );

  // The surrounding system: requesting masters plus the status slave.
  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
    input  m_axi_araddr, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/axi_sts_arb_picker.sv
// Combinational grant picker. AXI_STS_ARB_RR_EN selects round-robin rotation
// starting after last_grant; otherwise a lowest-index-wins priority encoder.
module axi_sts_arb_picker
  import axi_sts_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned GRANT_W     = grant_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
`ifdef AXI_STS_ARB_RR_EN
  input  logic [GRANT_W-1:0]     last_grant,
`endif
  output logic [GRANT_W-1:0]     grant,
  output logic                   any_req
);

  assign any_req = |req;

`ifdef AXI_STS_ARB_RR_EN
  logic [GRANT_W-1:0] idx_s;
  logic               found_s;
  logic               hit_s;

  // Walk the masters from last_grant+1 around the ring; the first requester wins.
  always_comb begin
    grant   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
      idx_s   = GRANT_W'((int'(last_grant) + k) % int'(NUM_MASTERS));
      hit_s   = !found_s && req[idx_s];
      grant   = hit_s ? idx_s : grant;
      found_s = found_s | hit_s;
    end
  end
`else
  // Scan from the top down so the lowest requesting index is the last to write.
  always_comb begin
    grant = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      grant = req[i] ? GRANT_W'(i) : grant;
    end
  end
`endif

endmodule

// File: rtl/axi_sts_arbiter.sv
// Shares one read-only AXI4-Lite status slave among NUM_MASTERS read masters,
// one read at a time. Define AXI_STS_ARB_RR_EN for round-robin, else fixed priority.
module axi_sts_arbiter
  import axi_sts_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  axi_sts_arb_if.slave bus
);

  localparam int unsigned GRANT_W = grant_width(NUM_MASTERS);

  arb_state_e                state_r;
  arb_state_e                state_s;
  logic [GRANT_W-1:0]        grant_r;
  logic [GRANT_W-1:0]        pick_s;
  logic                      any_req_s;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [NUM_MASTERS-1:0]    arready_r;
  logic [NUM_MASTERS-1:0]    grant_onehot_s;
  logic                      m_arvalid_s;
  logic                      m_rready_s;
  logic [NUM_MASTERS-1:0]    s_rvalid_s;
`ifdef AXI_STS_ARB_RR_EN
  logic [GRANT_W-1:0]        last_grant_r;
`endif

  axi_sts_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .GRANT_W     (GRANT_W)
  ) u_picker (
    .req        (bus.s_axi_arvalid),
`ifdef AXI_STS_ARB_RR_EN
    .last_grant (last_grant_r),
`endif
    .grant      (pick_s),
    .any_req    (any_req_s)
  );

  assign grant_onehot_s = NUM_MASTERS'(1'b1) << grant_r;

  // State register plus grant/address capture; arready is a one-cycle pulse at grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      addr_r       <= '0;
      arready_r    <= '0;
`ifdef AXI_STS_ARB_RR_EN
      last_grant_r <= GRANT_W'(NUM_MASTERS - 1);
`endif
    end else begin
      state_r   <= state_s;
      arready_r <= '0;
      if (state_r == IDLE && any_req_s) begin
        grant_r      <= pick_s;
        addr_r       <= bus.s_axi_araddr[pick_s*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        arready_r    <= NUM_MASTERS'(1'b1) << pick_s;
`ifdef AXI_STS_ARB_RR_EN
        last_grant_r <= pick_s;
`endif
      end
    end
  end

  // Next-state and channel steering; the response path only opens in DATA.
  always_comb begin
    state_s     = state_r;
    m_arvalid_s = 1'b0;
    m_rready_s  = 1'b0;
    s_rvalid_s  = '0;
    case (state_r)
      IDLE: begin
        state_s = any_req_s ? ADDR : IDLE;
      end
      ADDR: begin
        m_arvalid_s = 1'b1;
        state_s     = bus.m_axi_arready ? DATA : ADDR;
      end
      DATA: begin
        m_rready_s = bus.s_axi_rready[grant_r];
        s_rvalid_s = bus.m_axi_rvalid ? grant_onehot_s : '0;
        state_s    = (bus.m_axi_rvalid && bus.s_axi_rready[grant_r]) ? IDLE : DATA;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.s_axi_arready = arready_r;
  assign bus.s_axi_rvalid  = s_rvalid_s;
  assign bus.s_axi_rdata   = bus.m_axi_rdata;
  assign bus.s_axi_rresp   = bus.m_axi_rresp;
  assign bus.m_axi_araddr  = addr_r;
  assign bus.m_axi_arvalid = m_arvalid_s;
  assign bus.m_axi_rready  = m_rready_s;

endmodule

// File: tb/tb_axi_sts_arbiter.sv
// Directed bench for axi_sts_arbiter with two masters; expected grant order
// follows AXI_STS_ARB_RR_EN.
module tb_axi_sts_arbiter;
  import axi_sts_arb_pkg::*;

  logic aclk;
  logic aresetn;
  int   vec_cnt;
  int   err_cnt;

  axi_sts_arb_if #(.NUM_MASTERS(2), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16)) bus ();

  axi_sts_arbiter #(
    .NUM_MASTERS    (2),
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (16)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One read from IDLE with an always-ready slave; leaves the FSM idle at cycle 3.
  task automatic xact(input string tag, input logic [1:0] req, input logic keep,
                      input logic [1:0] exp_g, input logic [15:0] exp_addr,
                      input logic [31:0] data, input logic [1:0] resp);
    bus.s_axi_arvalid = req;
    bus.m_axi_arready = 1'b1;
    @(negedge aclk);
    check_eq({tag, ".arready"},   bus.s_axi_arready, exp_g);
    check_eq({tag, ".m_arvalid"}, bus.m_axi_arvalid, 1'b1);
    check_eq({tag, ".m_araddr"},  bus.m_axi_araddr,  exp_addr);
    @(negedge aclk);
    if (!keep) bus.s_axi_arvalid = 2'b00;
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = data;
    bus.m_axi_rresp  = resp;
    #1;
    check_eq({tag, ".rvalid"},   bus.s_axi_rvalid,  exp_g);
    check_eq({tag, ".rdata"},    bus.s_axi_rdata,   data);
    check_eq({tag, ".rresp"},    bus.s_axi_rresp,   resp);
    check_eq({tag, ".arready2"}, bus.s_axi_arready, 2'b00);
    check_eq({tag, ".m_rready"}, bus.m_axi_rready,  1'b1);
    @(negedge aclk);
    bus.m_axi_rvalid = 1'b0;
    #1;
    check_eq({tag, ".idle_arvalid"}, bus.m_axi_arvalid, 1'b0);
    check_eq({tag, ".idle_rvalid"},  bus.s_axi_rvalid,  2'b00);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    aresetn = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arvalid = 2'b00;
    bus.s_axi_rready  = 2'b11;
    bus.m_axi_arready = 1'b1;
    bus.m_axi_rdata   = 32'h0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rvalid  = 1'b0;

    @(negedge aclk);
    @(negedge aclk);
    check_eq("rst.arready",   bus.s_axi_arready, 2'b00);
    check_eq("rst.rvalid",    bus.s_axi_rvalid,  2'b00);
    check_eq("rst.m_arvalid", bus.m_axi_arvalid, 1'b0);
    check_eq("rst.m_rready",  bus.m_axi_rready,  1'b0);
    check_eq("rst.m_araddr",  bus.m_axi_araddr,  16'h0000);
    check_eq("rst.state",     dut.state_r,       IDLE);
`ifdef AXI_STS_ARB_RR_EN
    check_eq("rst.last_grant", dut.last_grant_r, 1'b1);
`endif
    aresetn = 1'b1;

    // Single request from master 1.
    bus.s_axi_araddr = {16'h0008, 16'h0000};
    xact("single", 2'b10, 1'b0, 2'b10, 16'h0008, 32'hDEADBEEF, 2'b10);

    // Both masters requesting continuously for four reads.
    bus.s_axi_araddr = {16'h0204, 16'h0100};
`ifdef AXI_STS_ARB_RR_EN
    xact("cont0", 2'b11, 1'b1, 2'b01, 16'h0100, 32'hA0A0_0001, 2'b00);
    xact("cont1", 2'b11, 1'b1, 2'b10, 16'h0204, 32'hA0A0_0002, 2'b00);
    xact("cont2", 2'b11, 1'b1, 2'b01, 16'h0100, 32'hA0A0_0003, 2'b00);
    xact("cont3", 2'b11, 1'b0, 2'b10, 16'h0204, 32'hA0A0_0004, 2'b00);
`else
    xact("cont0", 2'b11, 1'b1, 2'b01, 16'h0100, 32'hA0A0_0001, 2'b00);
    xact("cont1", 2'b11, 1'b1, 2'b01, 16'h0100, 32'hA0A0_0002, 2'b00);
    xact("cont2", 2'b11, 1'b1, 2'b01, 16'h0100, 32'hA0A0_0003, 2'b00);
    xact("cont3", 2'b11, 1'b0, 2'b01, 16'h0100, 32'hA0A0_0004, 2'b00);
`endif

    // Backpressure from master 0 while master 1 waits.
    bus.s_axi_araddr  = {16'h0300, 16'h0200};
    bus.s_axi_arvalid = 2'b01;
    bus.s_axi_rready  = 2'b10;
    @(negedge aclk);
    check_eq("bp.arready", bus.s_axi_arready, 2'b01);
    check_eq("bp.m_araddr", bus.m_axi_araddr, 16'h0200);
    @(negedge aclk);
    bus.s_axi_arvalid = 2'b10;
    bus.m_axi_rvalid  = 1'b1;
    bus.m_axi_rdata   = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp.state",     dut.state_r,       DATA);
      check_eq("bp.rvalid",    bus.s_axi_rvalid,  2'b01);
      check_eq("bp.m_rready",  bus.m_axi_rready,  1'b0);
      check_eq("bp.arready_h", bus.s_axi_arready, 2'b00);
      check_eq("bp.m_arvalid", bus.m_axi_arvalid, 1'b0);
      check_eq("bp.rdata",     bus.s_axi_rdata,   32'h1234_5678);
      @(negedge aclk);
    end
    bus.s_axi_rready = 2'b11;
    #1;
    check_eq("bp.release", bus.m_axi_rready, 1'b1);
    @(negedge aclk);
    bus.m_axi_rvalid = 1'b0;
    #1;
    check_eq("bp.idle_arready", bus.s_axi_arready, 2'b00);
    check_eq("bp.idle_state",   dut.state_r,       IDLE);
    xact("bp_m1", 2'b10, 1'b0, 2'b10, 16'h0300, 32'h0BAD_F00D, 2'b00);

    // Slave holds arready low for three cycles.
    bus.s_axi_araddr  = {16'h0000, 16'h0040};
    bus.s_axi_arvalid = 2'b01;
    bus.m_axi_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check_eq("stall.m_arvalid", bus.m_axi_arvalid, 1'b1);
      check_eq("stall.m_araddr",  bus.m_axi_araddr,  16'h0040);
      check_eq("stall.arready",   bus.s_axi_arready, (i == 0) ? 2'b01 : 2'b00);
      if (i == 1) bus.s_axi_arvalid = 2'b00;
    end
    bus.m_axi_arready = 1'b1;
    @(negedge aclk);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rdata  = 32'h0000_0040;
    #1;
    check_eq("stall.rvalid", bus.s_axi_rvalid, 2'b01);
    @(negedge aclk);
    bus.m_axi_rvalid = 1'b0;

    // Asynchronous reset while master 0 sits in DATA.
    bus.s_axi_araddr  = {16'h0000, 16'h0010};
    bus.s_axi_arvalid = 2'b01;
    bus.s_axi_rready  = 2'b00;
    @(negedge aclk);
    check_eq("rdata.arready", bus.s_axi_arready, 2'b01);
    @(negedge aclk);
    bus.s_axi_arvalid = 2'b00;
    bus.m_axi_rvalid  = 1'b1;
    bus.s_axi_rready  = 2'b01;
    #1;
    check_eq("rdata.rvalid_pre",  bus.s_axi_rvalid, 2'b01);
    check_eq("rdata.m_rready_pre", bus.m_axi_rready, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    check_eq("rdata.rvalid",    bus.s_axi_rvalid,  2'b00);
    check_eq("rdata.m_rready",  bus.m_axi_rready,  1'b0);
    check_eq("rdata.m_arvalid", bus.m_axi_arvalid, 1'b0);
    check_eq("rdata.arready",   bus.s_axi_arready, 2'b00);
    check_eq("rdata.m_araddr",  bus.m_axi_araddr,  16'h0000);
    bus.m_axi_rvalid = 1'b0;
    bus.s_axi_rready = 2'b11;
    @(negedge aclk);
    aresetn = 1'b1;
    bus.s_axi_araddr = {16'h0A02, 16'h0A00};
    xact("post_rst", 2'b11, 1'b0, 2'b01, 16'h0A00, 32'hCAFE_0001, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
